// File: rtl/aes_enc_scheduler.sv
`timescale 1ns/1ps
// Two-requester scheduler in front of one AES encryption core and its key-expansion unit.
// Build macro AES_SCHED_TIMEOUT_EN adds a RUN watchdog that returns an error response.

module aes_enc_scheduler #(
  parameter int unsigned KEY_SETTLE     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned DATA_W        = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_key,
  input  logic [DATA_W-1:0] req0_pt,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_key,
  input  logic [DATA_W-1:0] req1_pt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              set_new_key,
  output logic [DATA_W-1:0] key_in,
  output logic [DATA_W-1:0] plain_text,
  output logic              start,
  input  logic              ready_enc,
  input  logic              done_enc,
  input  logic [DATA_W-1:0] cipher_text
);

  // One counter serves both the key-settle wait and the RUN watchdog.
  localparam int unsigned TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W    = (TMO_BITS > 4) ? TMO_BITS : 4;

  typedef enum logic [2:0] {
    IDLE, KEY_LOAD, KEY_WAIT, START, RUN, RESP
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   key_q, key_d;
  logic [DATA_W-1:0]   pt_q, pt_d;
  logic                id_q, id_d;
  logic [DATA_W-1:0]   loaded_key_q, loaded_key_d;
  logic                key_valid_q, key_valid_d;
  logic                last_grant_q, last_grant_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                grant;
`ifdef AES_SCHED_TIMEOUT_EN
  logic                rsp_err_q, rsp_err_d;
`endif

  // State register and job context
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      key_q        <= '0;
      pt_q         <= '0;
      id_q         <= 1'b0;
      loaded_key_q <= '0;
      key_valid_q  <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      rsp_data_q   <= '0;
`ifdef AES_SCHED_TIMEOUT_EN
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      pt_q         <= pt_d;
      id_q         <= id_d;
      loaded_key_q <= loaded_key_d;
      key_valid_q  <= key_valid_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      done_q       <= done_enc;
      rsp_data_q   <= rsp_data_d;
`ifdef AES_SCHED_TIMEOUT_EN
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  // Next-state, grant and core-strobe logic
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    pt_d         = pt_q;
    id_d         = id_q;
    loaded_key_d = loaded_key_q;
    key_valid_d  = key_valid_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    rsp_data_d   = rsp_data_q;
`ifdef AES_SCHED_TIMEOUT_EN
    rsp_err_d    = rsp_err_q;
`endif
    grant        = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    set_new_key  = 1'b0;
    start        = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          // Round-robin only matters when both ask in the same cycle.
          grant      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
          req0_ready = ~grant;
          req1_ready = grant;
          key_d      = grant ? req1_key : req0_key;
          pt_d       = grant ? req1_pt  : req0_pt;
          id_d       = grant;
          state_d    = (!key_valid_q || (key_d != loaded_key_q)) ? KEY_LOAD : START;
        end
      end
      KEY_LOAD: begin
        set_new_key  = 1'b1;
        loaded_key_d = key_q;
        key_valid_d  = 1'b1;
        cnt_d        = '0;
        state_d      = KEY_WAIT;
      end
      KEY_WAIT: begin
        if (cnt_q == CNT_W'(KEY_SETTLE - 1)) begin
          cnt_d   = '0;
          state_d = START;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      START: begin
        if (ready_enc) begin
          start   = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Edge-detect so a held done_enc level is captured once.
        if (done_enc && !done_q) begin
          rsp_data_d = cipher_text;
`ifdef AES_SCHED_TIMEOUT_EN
          rsp_err_d  = 1'b0;
`endif
          state_d    = RESP;
        end
`ifdef AES_SCHED_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          key_valid_d = 1'b0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          last_grant_d = id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign key_in     = key_q;
  assign plain_text = pt_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = (state_q != IDLE);
`ifdef AES_SCHED_TIMEOUT_EN
  assign rsp_err    = rsp_err_q;
`else
  assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_aes_enc_scheduler.sv
`timescale 1ns/1ps
// Directed bench for aes_enc_scheduler with a behavioural AES core that answers from known vectors.

module tb_aes_enc_scheduler;
  localparam int unsigned KS  = 2;
  localparam int unsigned TMO = 64;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C2 = 128'h8df4e9aac5c7573a27d8d055d6e4d64b;
  localparam logic [127:0] C3 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] JUNK = 128'hdeadbeef_0badf00d_feedface_c001d00d;

  logic clk = 1'b0;
  logic reset_n;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [127:0] req0_key, req0_pt, req1_key, req1_pt;
  logic rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [127:0] rsp_data, key_in, plain_text, cipher_text;
  logic set_new_key, start, ready_enc, done_enc;

  aes_enc_scheduler #(.KEY_SETTLE(KS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_key(req0_key), .req0_pt(req0_pt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_key(req1_key), .req1_pt(req1_pt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .set_new_key(set_new_key), .key_in(key_in),
    .plain_text(plain_text), .start(start), .ready_enc(ready_enc), .done_enc(done_enc),
    .cipher_text(cipher_text)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] aes_lut(input logic [127:0] k, input logic [127:0] p);
    if (k == K1 && p == P1) return C1;
    if (k == K1 && p == P2) return C2;
    if (k == K2 && p == P2) return C3;
    return k ^ p ^ 128'h5a5a5a5a_5a5a5a5a_5a5a5a5a_5a5a5a5a;
  endfunction

  // Core model: done_enc high for three cycles starting two cycles after start; a stray
  // one-cycle done_enc glitch follows every key load to exercise the out-of-RUN filter.
  int           tmr = 0;
  logic [127:0] core_key = '0;
  logic [127:0] core_pt = '0;
  logic         glitch_q = 1'b0;
  logic         core_en;
  logic         model_done;

  always @(posedge clk) begin
    if (!reset_n) begin
      tmr      <= 0;
      glitch_q <= 1'b0;
    end else begin
      glitch_q <= set_new_key;
      if (set_new_key) core_key <= key_in;
      if (start) begin
        core_pt <= plain_text;
        tmr     <= 1;
      end else if (tmr != 0) begin
        tmr <= (tmr >= 6) ? 0 : tmr + 1;
      end
    end
  end

  assign model_done  = core_en && (tmr >= 3) && (tmr <= 5);
  assign done_enc    = model_done || glitch_q;
  assign cipher_text = model_done ? aes_lut(core_key, core_pt) : JUNK;

  // Event monitors
  int   cyc = 0;
  int   loads = 0, starts = 0, start_cyc = 0, edge_cyc = 0;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (set_new_key) loads++;
    if (start) begin
      starts++;
      start_cyc = cyc;
    end
    if (done_enc && !done_prev) edge_cyc = cyc;
    done_prev = done_enc;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         v0;
    logic         v1;
    logic [127:0] k0;
    logic [127:0] p0;
    logic [127:0] k1;
    logic [127:0] p1;
    logic         exp_id;
    logic [127:0] exp_data;
    int           exp_loads;
  } vec_t;

  vec_t vecs [6];

  // Called #1 after a posedge; returns #1 after the response handshake edge.
  task automatic run_job(input vec_t v, input string tag);
    int  l0, s0, g_cyc, exp_lat;
    bit  got, gid;
    l0 = loads; s0 = starts; g_cyc = -100; got = 1'b0;
    req0_valid = v.v0; req0_key = v.k0; req0_pt = v.p0;
    req1_valid = v.v1; req1_key = v.k1; req1_pt = v.p1;
    exp_lat = (v.exp_loads != 0) ? int'(2 + KS) : 1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        g_cyc = cyc;
        gid   = req1_ready;
        check({tag, "_grant"}, 128'({req0_ready, req1_ready}), v.exp_id ? 128'd1 : 128'd2);
        @(posedge clk); #1;
        if (gid) req1_valid = 1'b0;
        else     req0_valid = 1'b0;
      end else if (rsp_valid) begin
        check({tag, "_id"},    128'(rsp_id), 128'(v.exp_id));
        check({tag, "_data"},  rsp_data, v.exp_data);
        check({tag, "_err"},   128'(rsp_err), 128'd0);
        check({tag, "_loads"}, 128'(loads - l0), 128'(v.exp_loads));
        check({tag, "_starts"}, 128'(starts - s0), 128'd1);
        check({tag, "_start_lat"}, 128'(start_cyc - g_cyc), 128'(exp_lat));
        check({tag, "_rsp_lat"}, 128'(cyc - edge_cyc), 128'd1);
        rsp_ready = 1'b1;
        got = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
      end
    end
    check({tag, "_completed"}, 128'(got), 128'd1);
  endtask

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           seen;
    vec_t         v;
    logic [127:0] hold_data;
    int           s0, lat;

    vecs[0] = '{1'b1, 1'b0, K1, P1, '0, '0, 1'b0, C1, 1};
    vecs[1] = '{1'b1, 1'b0, K1, P2, '0, '0, 1'b0, C2, 0};
    vecs[2] = '{1'b1, 1'b1, K1, P1, K2, P2, 1'b0, C1, 1};
    vecs[3] = '{1'b0, 1'b1, '0, '0, K2, P2, 1'b1, C3, 1};
    vecs[4] = '{1'b1, 1'b1, K1, P2, K2, P2, 1'b0, C2, 1};
    vecs[5] = '{1'b0, 1'b1, '0, '0, K2, P2, 1'b1, C3, 1};

    reset_n = 1'b0; rsp_ready = 1'b0; ready_enc = 1'b1; core_en = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_key = '0; req0_pt = '0; req1_key = '0; req1_pt = '0;

    repeat (3) @(negedge clk);
    check("rst_ctrl", 128'({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, busy, set_new_key, start}), 128'd0);
    check("rst_key_in", key_in, '0);
    check("rst_plain_text", plain_text, '0);
    check("rst_rsp_data", rsp_data, '0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_job(vecs[0], "miss_after_reset");
    run_job(vecs[1], "key_hit");

    // Fresh reset so arbitration starts from last_grant=1.
    do_reset();
    for (int i = 2; i < 6; i++) run_job(vecs[i], $sformatf("contend%0d", i - 1));

    // ready_enc low holds START; then rsp_ready low holds the response.
    s0 = starts; seen = 1'b0;
    ready_enc = 1'b0;
    req0_valid = 1'b1; req0_key = K2; req0_pt = P2;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (req0_ready) begin
        seen = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
      end
    end
    check("bp_granted", 128'(seen), 128'd1);
    repeat (4) @(negedge clk);
    check("start_held", 128'({busy, 8'(starts - s0)}), 128'h100);
    @(posedge clk); #1;
    ready_enc = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("bp_rsp_seen", 128'(seen), 128'd1);
    check("bp_rsp_data", rsp_data, C3);
    check("bp_one_start", 128'(starts - s0), 128'd1);
    hold_data = rsp_data;
    req1_valid = 1'b1; req1_key = K1; req1_pt = P1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_ctrl", 128'({rsp_valid, rsp_id, req0_ready, req1_ready, start, busy}), 128'b100001);
      check("bp_hold_data", rsp_data, hold_data);
    end
    rsp_ready = 1'b1;
    #1;
    check("hs_no_grant", 128'(req1_ready), 128'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check("dropped_req_idle", 128'({busy, req1_ready, set_new_key}), 128'd0);
    @(posedge clk); #1;

    // Reset asserted while the core is running.
    seen = 1'b0;
    req0_valid = 1'b1; req0_key = K2; req0_pt = P2;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (req0_ready) begin
        @(posedge clk); #1;
        req0_valid = 1'b0;
      end else if (start) begin
        seen = 1'b1;
      end
    end
    check("mid_run_start_seen", 128'(seen), 128'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ctrl", 128'({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, busy, set_new_key, start}), 128'd0);
    check("mid_rst_key_in", key_in, '0);
    check("mid_rst_plain_text", plain_text, '0);
    check("mid_rst_rsp_data", rsp_data, '0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    v = '{1'b1, 1'b0, K2, P2, '0, '0, 1'b0, C3, 1};
    run_job(v, "reload_after_reset");

`ifdef AES_SCHED_TIMEOUT_EN
    // Core never answers: expect an error response and a forced key reload afterwards.
    core_en = 1'b0;
    seen = 1'b0;
    req0_valid = 1'b1; req0_key = K2; req0_pt = P2;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (req0_ready) begin
        @(posedge clk); #1;
        req0_valid = 1'b0;
      end else if (rsp_valid) begin
        seen = 1'b1;
      end
    end
    lat = cyc - start_cyc;
    check("tmo_rsp_seen", 128'(seen), 128'd1);
    check("tmo_err", 128'(rsp_err), 128'd1);
    check("tmo_data", rsp_data, '0);
    check("tmo_id", 128'(rsp_id), 128'd0);
    check("tmo_latency_in_range", 128'((lat >= int'(TMO)) && (lat <= int'(TMO) + 2)), 128'd1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    core_en = 1'b1;
    run_job(v, "reload_after_timeout");
`else
    lat = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
